// File: rtl/multiplicador_secuencial.sv
// Sequential shift-and-add unsigned multiplier: N iterations through one sumador_N,
// 2N-bit product held in result until the next completion.

module sumador_N #(
    parameter int N = 4
) (
    input  logic [N-1:0] A_num,
    input  logic [N-1:0] B_num,
    input  logic         carry_in,
    output logic [N-1:0] S,
    output logic         carry_out
);
    logic [N:0] sum;

    always_comb begin
        sum       = {1'b0, A_num} + {1'b0, B_num} + {{N{1'b0}}, carry_in};
        S         = sum[N-1:0];
        carry_out = sum[N];
    end
endmodule

module multiplicador_secuencial #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   A_num,
    input  logic [N-1:0]   B_num,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] result
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   m_q, m_d;
    logic [2*N-1:0] p_q, p_d;
    logic [2*N-1:0] result_q, result_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [N-1:0]   add_b;
    logic [N-1:0]   add_s;
    logic           add_c;
    logic           last_iter;

    // Adding zero when the multiplier bit is clear yields c=0, s=accumulator.
    assign add_b = p_q[0] ? m_q : '0;

    sumador_N #(.N(N)) u_sumador (
        .A_num    (p_q[2*N-1:N]),
        .B_num    (add_b),
        .carry_in (1'b0),
        .S        (add_s),
        .carry_out(add_c)
    );

    assign last_iter = (cnt_q == CW'(N - 1));

    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        p_d      = p_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = BUSY;
                    m_d     = A_num;
                    p_d     = {{N{1'b0}}, B_num};
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                p_d   = {add_c, add_s, p_q[N-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    state_d  = DONE;
                    result_d = p_d;
                end
            end
            DONE: begin
                // Result is already committed here, so a new request can be accepted
                // on the DONE->IDLE edge, giving one operation every N+1 cycles.
                if (start) begin
                    state_d = BUSY;
                    m_d     = A_num;
                    p_d     = {{N{1'b0}}, B_num};
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            m_q      <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            p_q      <= p_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
endmodule

// File: tb/tb_multiplicador_secuencial.sv
// Bench for multiplicador_secuencial: N=4 and N=8 instances checked every cycle
// against an edge-count timing model plus directed literal products.

module tb_multiplicador_secuencial;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start4 = 1'b0, start8 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy4, done4, busy8, done8;
    logic [7:0] res4;
    logic [15:0] res8;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    multiplicador_secuencial #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .A_num(a4), .B_num(b4),
        .busy(busy4), .done(done4), .result(res4)
    );

    multiplicador_secuencial #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .A_num(a8), .B_num(b8),
        .busy(busy8), .done(done8), .result(res8)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Timing model: after posedge e, an op accepted at edge acc is busy for
    // acc <= e <= acc+N, pulses done at e == acc+N, and result becomes a*b then.
    initial begin
        int          acc [2];
        bit          valid [2];
        logic [15:0] prod [2];
        logic [15:0] mres [2];
        int          nn [2];
        int          e;
        bit          eb, ed, st;
        logic [15:0] oa, ob, ores;
        logic        obusy, odone;
        nn[0] = 4; nn[1] = 8;
        valid[0] = 0; valid[1] = 0;
        mres[0] = '0; mres[1] = '0;
        acc[0] = 0; acc[1] = 0;
        prod[0] = '0; prod[1] = '0;
        e = 0;
        forever begin
            @(posedge clk);
            e++;
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (i == 0) begin
                    obusy = busy4; odone = done4; ores = {8'h00, res4};
                    st = start4; oa = {12'h000, a4}; ob = {12'h000, b4};
                end else begin
                    obusy = busy8; odone = done8; ores = res8;
                    st = start8; oa = {8'h00, a8}; ob = {8'h00, b8};
                end
                if (!rst_n) begin
                    valid[i] = 0;
                    mres[i] = '0;
                    chk($sformatf("rst busy[%0d]", i), {15'h0, obusy}, 16'h0);
                    chk($sformatf("rst done[%0d]", i), {15'h0, odone}, 16'h0);
                    chk($sformatf("rst result[%0d]", i), ores, 16'h0);
                end else begin
                    eb = valid[i] && e >= acc[i] && e <= acc[i] + nn[i];
                    ed = valid[i] && e == acc[i] + nn[i];
                    if (ed) mres[i] = prod[i];
                    chk($sformatf("model busy[%0d]", i), {15'h0, obusy}, {15'h0, eb});
                    chk($sformatf("model done[%0d]", i), {15'h0, odone}, {15'h0, ed});
                    chk($sformatf("model result[%0d]", i), ores, mres[i]);
                    if (st && (!valid[i] || e >= acc[i] + nn[i])) begin
                        valid[i] = 1;
                        acc[i] = e + 1;
                        prod[i] = oa * ob;
                    end
                end
            end
        end
    end

    task automatic drive(input int idx, input logic [7:0] a, input logic [7:0] b, input logic s);
        if (idx == 0) begin
            a4 = a[3:0]; b4 = b[3:0]; start4 = s;
        end else begin
            a8 = a; b8 = b; start8 = s;
        end
    endtask

    function automatic logic get_done(input int idx);
        return (idx == 0) ? done4 : done8;
    endfunction

    function automatic logic [15:0] get_res(input int idx);
        return (idx == 0) ? {8'h00, res4} : res8;
    endfunction

    task automatic run_op(input int idx, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp, input int lat, input string nm);
        int k;
        @(posedge clk); #1;
        drive(idx, a, b, 1'b1);
        @(posedge clk); #1;
        drive(idx, 8'hA5, 8'h5A, 1'b0);
        k = 0;
        while (!get_done(idx) && k < 30) begin
            @(posedge clk); #1;
            k++;
        end
        chk({nm, " latency"}, 16'(k), 16'(lat));
        chk({nm, " result"}, get_res(idx), exp);
        @(posedge clk); #1;
        chk({nm, " done width"}, {15'h0, get_done(idx)}, 16'h0);
    endtask

    initial begin
        int ndone, t1, t2, k;
        logic [15:0] r1, r2;
        #1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("idle result", {8'h00, res4}, 16'h0);
        chk("idle busy", {15'h0, busy4}, 16'h0);
        chk("idle done", {15'h0, done4}, 16'h0);

        run_op(0, 8'd0,  8'd0,  16'h0000, 4, "0*0");
        run_op(0, 8'd1,  8'd1,  16'h0001, 4, "1*1");
        run_op(0, 8'd15, 8'd1,  16'h000F, 4, "15*1");
        run_op(0, 8'd7,  8'd8,  16'h0038, 4, "7*8");
        run_op(0, 8'd15, 8'd15, 16'h00E1, 4, "15*15");

        // Start while busy: second request must be ignored.
        @(posedge clk); #1;
        drive(0, 8'd3, 8'd5, 1'b1);
        @(posedge clk); #1;
        drive(0, 8'd0, 8'd0, 1'b0);
        @(posedge clk); #1;
        drive(0, 8'd15, 8'd15, 1'b1);
        @(posedge clk); #1;
        drive(0, 8'd0, 8'd0, 1'b0);
        ndone = 0; r1 = '0;
        for (int c = 0; c < 15; c++) begin
            if (done4) begin ndone++; r1 = {8'h00, res4}; end
            @(posedge clk); #1;
        end
        chk("busy-start done count", 16'(ndone), 16'd1);
        chk("busy-start result", r1, 16'h000F);

        // Back-to-back with start held high.
        @(posedge clk); #1;
        drive(0, 8'd2, 8'd3, 1'b1);
        @(posedge clk); #1;
        drive(0, 8'd9, 8'd9, 1'b1);
        ndone = 0; t1 = 0; t2 = 0; r1 = '0; r2 = '0;
        for (int c = 1; c < 20; c++) begin
            if (ndone == 1 && !done4) start4 = 1'b0;
            if (done4) begin
                ndone++;
                if (ndone == 1) begin t1 = c; r1 = {8'h00, res4}; end
                else if (ndone == 2) begin t2 = c; r2 = {8'h00, res4}; end
            end
            @(posedge clk); #1;
        end
        start4 = 1'b0;
        chk("b2b done count", 16'(ndone), 16'd2);
        chk("b2b first", r1, 16'h0006);
        chk("b2b second", r2, 16'h0051);
        chk("b2b spacing", 16'(t2 - t1), 16'd5);

        // Reset in the middle of 15*15.
        @(posedge clk); #1;
        drive(0, 8'd15, 8'd15, 1'b1);
        @(posedge clk); #1;
        drive(0, 8'd0, 8'd0, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst busy", {15'h0, busy4}, 16'h0);
        chk("async rst done", {15'h0, done4}, 16'h0);
        chk("async rst result", {8'h00, res4}, 16'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            if (done4) k++;
            @(posedge clk); #1;
        end
        chk("aborted no done", 16'(k), 16'd0);
        run_op(0, 8'd4, 8'd4, 16'h0010, 4, "4*4");

        run_op(1, 8'd255, 8'd255, 16'hFE01, 8, "N8 255*255");
        run_op(1, 8'd200, 8'd3,   16'h0258, 8, "N8 200*3");
        run_op(1, 8'd0,   8'd77,  16'h0000, 8, "N8 0*77");

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end
endmodule
